sn_uart_tx: RTL
===============

SN_UART_TX -- requirements
Module: sn_uart_tx

Interface
REQ-001 SHALL have parameter P_CLKS_PER_BIT, default 87: clk cycles per UART bit.
REQ-002 SHALL have parameter P_DATA_BW, default 8: data bits per frame.
REQ-003 SHALL have parameter P_FIFO_DEPTH, default 4: byte FIFO entries, power of 2, at least 2.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tx_data  input  P_DATA_BW  byte to send.
REQ-007 SHALL have port tx_valid  input  1  tx_data valid.
REQ-008 SHALL have port tx_ready  output  1  FIFO can accept a byte.
REQ-009 SHALL have port tx_output  output  1  serial line, idle high, registered.
REQ-010 SHALL have port tx_busy  output  1  frame in progress or FIFO non-empty.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at end of each stop bit.
REQ-012 SHALL have port fifo_count  output  $clog2(P_FIFO_DEPTH+1)  FIFO occupancy.

Function
REQ-013 SHALL accept a byte into the FIFO on a rising edge where tx_valid=1 and tx_ready=1.
REQ-014 SHALL drive tx_ready = (fifo_count < P_FIFO_DEPTH).
- A pop in the same cycle does not raise tx_ready.
REQ-015 SHALL ignore tx_valid while tx_ready=0, with no FIFO or count change.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, plus PARITY when the configuration macro is set.
REQ-017 SHALL pop the FIFO head and enter START on the first edge where state=IDLE and the FIFO is non-empty.
- tx_output goes low 1 cycle after the accepting edge when the FIFO was empty.
REQ-018 SHALL hold each bit for exactly P_CLKS_PER_BIT cycles using a bit timer counting 0..P_CLKS_PER_BIT-1.
REQ-019 SHALL send the start bit (0), then P_DATA_BW data bits LSB first, then one stop bit (1).
REQ-020 SHALL pulse tx_done for exactly one cycle on the last cycle of the stop bit.
REQ-021 SHALL, when the FIFO is non-empty at the end of STOP, pop and go directly to START with no idle gap; otherwise it SHALL go to IDLE.
REQ-022 SHALL give a push and a pop in the same edge a net fifo_count change of 0, preserving order.
REQ-023 SHALL wrap read and write pointers modulo P_FIFO_DEPTH.
REQ-024 SHALL drive tx_busy = (state != IDLE) or (fifo_count != 0).

Reset
REQ-025 SHALL, while rst=0, immediately force:
- tx_output=1, tx_ready=1, tx_busy=0, tx_done=0, fifo_count=0
- state=IDLE, bit timer=0, pointers=0
REQ-026 SHALL abort any frame in progress on reset, discard FIFO contents and send no partial frame after release.

Configuration
REQ-027 SHALL compile an even-parity bit when macro SN_UART_TX_PARITY_EN is defined.
- PARITY state between DATA and STOP sends the XOR of the data bits.
- Frame length is P_DATA_BW+3 bits.
REQ-028 SHALL, without SN_UART_TX_PARITY_EN, have no PARITY state and a frame length of P_DATA_BW+2 bits.

Verification
REQ-029 SHALL check reset: rst=0 -> tx_output=1, tx_ready=1, tx_busy=0, fifo_count=0, and tx_output stays 1 for 1000 cycles after release.
REQ-030 SHALL check one byte: push 0xA5 -> line sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1 at 87 cycles per bit; tx_done pulses once, 870 cycles after the start-bit fall.
REQ-031 SHALL check back-to-back: push 5 bytes on consecutive cycles -> all accepted; tx_ready=0 with fifo_count=4; 5 contiguous frames in 4350 cycles with no idle-high gap.
REQ-032 SHALL check full FIFO: hold tx_valid=1 with changing tx_data while full -> no extra bytes transmitted; the byte offered on the first tx_ready=1 cycle is the next one accepted.
REQ-033 SHALL check mid-frame reset: assert rst=0 during data bit 3 with 2 bytes queued -> tx_output=1 immediately, fifo_count=0, nothing transmitted after release.
REQ-034 SHALL check parity with SN_UART_TX_PARITY_EN defined: push 0x07 -> parity bit=1, frame 11 bits, tx_done 957 cycles after the start-bit fall.

Source files
------------

// File: rtl/sn_uart_tx.sv
// FIFO-buffered UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Optional parity bit is compiled in when SN_UART_TX_PARITY_EN is defined.
module sn_uart_tx #(
  parameter int unsigned P_CLKS_PER_BIT = 87,
  parameter int unsigned P_DATA_BW      = 8,
  parameter int unsigned P_FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [P_DATA_BW-1:0]                 tx_data,
  input  logic                                 tx_valid,
  output logic                                 tx_ready,
  output logic                                 tx_output,
  output logic                                 tx_busy,
  output logic                                 tx_done,
  output logic [$clog2(P_FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int unsigned LP_CW = $clog2(P_FIFO_DEPTH + 1);
  localparam int unsigned LP_PW = $clog2(P_FIFO_DEPTH);
  localparam int unsigned LP_TW = (P_CLKS_PER_BIT > 1) ? $clog2(P_CLKS_PER_BIT) : 1;
  localparam int unsigned LP_BW = (P_DATA_BW > 1) ? $clog2(P_DATA_BW) : 1;

  localparam logic [LP_TW-1:0] LP_T_LAST   = LP_TW'(P_CLKS_PER_BIT - 1);
  localparam logic [LP_TW-1:0] LP_T_PRE    = (P_CLKS_PER_BIT > 1) ? LP_TW'(P_CLKS_PER_BIT - 2) : '0;
  localparam logic [LP_BW-1:0] LP_BIT_LAST = LP_BW'(P_DATA_BW - 1);
  localparam logic [LP_CW-1:0] LP_DEPTH    = LP_CW'(P_FIFO_DEPTH);
  localparam logic             LP_ONE_CLK  = (P_CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef SN_UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  logic [P_DATA_BW-1:0] r_mem [P_FIFO_DEPTH];
  logic [LP_PW-1:0]     r_wr_ptr;
  logic [LP_PW-1:0]     r_rd_ptr;
  logic [LP_CW-1:0]     r_count;

  state_t               r_state;
  logic [LP_TW-1:0]     r_timer;
  logic [LP_BW-1:0]     r_bit_idx;
  logic [P_DATA_BW-1:0] r_shift;
  logic                 r_tx;
  logic                 r_done;
`ifdef SN_UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic                 w_ready;
  logic                 w_nonempty;
  logic                 w_bit_end;
  logic                 w_push;
  logic                 w_pop;
  logic [P_DATA_BW-1:0] w_head;
  logic [P_DATA_BW-1:0] w_shift_next;

  assign w_ready      = (r_count < LP_DEPTH);
  assign w_nonempty   = (r_count != '0);
  assign w_bit_end    = (r_timer == LP_T_LAST);
  assign w_push       = tx_valid && w_ready;
  // Pop either from idle or on the final stop-bit cycle so frames chain with no gap.
  assign w_pop        = w_nonempty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head       = r_mem[r_rd_ptr];
  assign w_shift_next = r_shift >> 1;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + LP_CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - LP_CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
`ifdef SN_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_timer <= '0;
        if (w_pop) begin
          r_state <= S_START;
          r_shift <= w_head;
          r_tx    <= 1'b0;
`ifdef SN_UART_TX_PARITY_EN
          r_parity <= ^w_head;
`endif
        end
      end else if (!w_bit_end) begin
        r_timer <= r_timer + LP_TW'(1);
        // tx_done is registered, so it is armed one cycle ahead of the last stop cycle.
        if ((r_state == S_STOP) && (r_timer == LP_T_PRE)) begin
          r_done <= 1'b1;
        end
      end else begin
        r_timer <= '0;
        case (r_state)
          S_START: begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end
          S_DATA: begin
            if (r_bit_idx == LP_BIT_LAST) begin
`ifdef SN_UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
              r_done  <= LP_ONE_CLK;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + LP_BW'(1);
              r_shift   <= w_shift_next;
              r_tx      <= w_shift_next[0];
            end
          end
`ifdef SN_UART_TX_PARITY_EN
          S_PARITY: begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
            r_done  <= LP_ONE_CLK;
          end
`endif
          S_STOP: begin
            if (w_pop) begin
              r_state <= S_START;
              r_shift <= w_head;
              r_tx    <= 1'b0;
`ifdef SN_UART_TX_PARITY_EN
              r_parity <= ^w_head;
`endif
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx_ready   = w_ready;
  assign tx_output  = r_tx;
  assign tx_done    = r_done;
  assign fifo_count = r_count;
  assign tx_busy    = (r_state != S_IDLE) || w_nonempty;

endmodule
